// File: rtl/jtpang_sched_pkg.sv
// Shared types for the three-slot SDRAM bank read scheduler: FSM states,
// slot ids, bank geometry and the round-robin pick helper.
package jtpang_sched_pkg;
  localparam int NSLOTS  = 3;
  localparam int BANK_AW = 22;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, RECV2} state_t;
  typedef logic [1:0]         slot_t;
  typedef logic [BANK_AW-1:0] baddr_t;

  // First pending slot at or after ptr; walking downwards lets the nearest win.
  function automatic slot_t rr_pick(logic [NSLOTS-1:0] pend, slot_t ptr);
    slot_t w;
    int    idx;
    w = ptr;
    for (int k = NSLOTS-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NSLOTS;
      if (pend[idx]) w = slot_t'(idx);
    end
    return w;
  endfunction
endpackage

// File: rtl/jtpang_bank_sched_if.sv
// Bank-side handshake between the read scheduler (master) and the SDRAM
// controller (slave).
interface jtpang_bank_sched_if;
  import jtpang_sched_pkg::*;
  baddr_t      sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;

  modport master (output sdram_addr, sdram_req,
                  input  sdram_ack, data_dst, data_rdy, data_read);
  modport slave  (input  sdram_addr, sdram_req,
                  output sdram_ack, data_dst, data_rdy, data_read);
endinterface

// File: rtl/jtpang_sched_cache.sv
// Per-slot single-entry read cache: address translation into the bank,
// hit detection, byte-lane select and the registered ok/dout outputs.
module jtpang_sched_cache
  import jtpang_sched_pkg::*;
#(
  parameter int     AW     = 18,
  parameter int     DW     = 8,
  parameter baddr_t OFFSET = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [AW-1:0]                    addr,
  input  logic                             cs,
  input  logic                             busy,
  input  logic                             grant,
  input  logic                             fill,
  input  logic [((DW == 32) ? 32 : 16)-1:0] fill_data,
  output logic                             pending,
  output baddr_t                           word_addr,
  output logic [DW-1:0]                    dout,
  output logic                             ok
);
  localparam int TW = (DW == 8)  ? AW-1 : AW;
  localparam int CW = (DW == 32) ? 32   : 16;

  logic [TW-1:0] tag, req_tag, cur_tag;
  logic [CW-1:0] data, lane;
  logic          valid, hit;

  // Byte slots cache whole 16-bit words; the live addr[0] picks the lane.
  always_comb begin
    cur_tag = (DW == 8) ? TW'(addr >> 1) : TW'(addr);
    if (DW == 32) word_addr = OFFSET + BANK_AW'({cur_tag, 1'b0});
    else          word_addr = OFFSET + BANK_AW'(cur_tag);
    hit     = cs & valid & (tag == cur_tag);
    pending = cs & ~hit & ~busy;
    lane    = (DW == 8 && addr[0]) ? CW'(data >> 8) : data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      tag     <= '0;
      req_tag <= '0;
      data    <= '0;
      dout    <= '0;
      ok      <= 1'b0;
    end else begin
      ok <= hit;
      if (hit)   dout    <= DW'(lane);
      if (grant) req_tag <= cur_tag;
      // The fill is tagged with the address latched at grant, not the live one.
      if (fill) begin
        valid <= 1'b1;
        tag   <= req_tag;
        data  <= fill_data;
      end
    end
  end
endmodule

// File: rtl/jtpang_bank_sched.sv
// Three-slot read scheduler sharing one SDRAM bank. Define
// JTPANG_SCHED_FIXPRIO_EN for fixed priority slot0 > slot1 > slot2.
module jtpang_bank_sched
  import jtpang_sched_pkg::*;
#(
  parameter int     SLOT0_AW     = 18,
  parameter int     SLOT0_DW     = 8,
  parameter baddr_t SLOT0_OFFSET = 22'h0,
  parameter int     SLOT1_AW     = 18,
  parameter int     SLOT1_DW     = 8,
  parameter baddr_t SLOT1_OFFSET = 22'h0,
  parameter int     SLOT2_AW     = 18,
  parameter int     SLOT2_DW     = 32,
  parameter baddr_t SLOT2_OFFSET = 22'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  input  logic                slot0_cs,
  output logic [SLOT0_DW-1:0] slot0_dout,
  output logic                slot0_ok,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  input  logic                slot1_cs,
  output logic [SLOT1_DW-1:0] slot1_dout,
  output logic                slot1_ok,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  input  logic                slot2_cs,
  output logic [SLOT2_DW-1:0] slot2_dout,
  output logic                slot2_ok,
  jtpang_bank_sched_if.master bank
);
  localparam logic [NSLOTS-1:0] IS32 = {SLOT2_DW == 32, SLOT1_DW == 32, SLOT0_DW == 32};
  localparam int CW0 = (SLOT0_DW == 32) ? 32 : 16;
  localparam int CW1 = (SLOT1_DW == 32) ? 32 : 16;
  localparam int CW2 = (SLOT2_DW == 32) ? 32 : 16;

  state_t            st;
  slot_t             sel, win;
  logic [15:0]       lo;
  logic [NSLOTS-1:0] pend, busy, grant, fill;
  baddr_t            waddr [NSLOTS];
  logic              fill_any;
  logic [31:0]       fill_word;

`ifndef JTPANG_SCHED_FIXPRIO_EN
  slot_t ptr;
  always_ff @(posedge clk)
    if (rst)       ptr <= '0;
    else if (|fill) ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
`endif

  always_comb begin
`ifdef JTPANG_SCHED_FIXPRIO_EN
    win = rr_pick(pend, 2'd0);
`else
    win = rr_pick(pend, ptr);
`endif
    fill_any  = (st == WAIT_DATA && bank.data_dst && !IS32[sel]) ||
                (st == RECV2 && bank.data_rdy);
    fill_word = (st == RECV2) ? {bank.data_read, lo} : {16'h0, bank.data_read};
    for (int i = 0; i < NSLOTS; i++) begin
      busy[i]  = (st != IDLE) && (sel == slot_t'(i));
      grant[i] = (st == IDLE) && (|pend) && (win == slot_t'(i));
      fill[i]  = fill_any && (sel == slot_t'(i));
    end
  end

  // dst/rdy only count in the data states, so strays after reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= IDLE;
      sel             <= '0;
      lo              <= '0;
      bank.sdram_req  <= 1'b0;
      bank.sdram_addr <= '0;
    end else begin
      case (st)
        IDLE: if (|pend) begin
          sel             <= win;
          bank.sdram_addr <= waddr[win];
          bank.sdram_req  <= 1'b1;
          st              <= WAIT_ACK;
        end
        WAIT_ACK: if (bank.sdram_ack) begin
          bank.sdram_req <= 1'b0;
          st             <= WAIT_DATA;
        end
        WAIT_DATA: if (bank.data_dst) begin
          if (IS32[sel]) begin
            lo <= bank.data_read;
            st <= RECV2;
          end else st <= IDLE;
        end
        RECV2: if (bank.data_rdy) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  jtpang_sched_cache #(.AW(SLOT0_AW), .DW(SLOT0_DW), .OFFSET(SLOT0_OFFSET)) u_slot0 (
    .clk(clk), .rst(rst), .addr(slot0_addr), .cs(slot0_cs), .busy(busy[0]),
    .grant(grant[0]), .fill(fill[0]), .fill_data(fill_word[CW0-1:0]),
    .pending(pend[0]), .word_addr(waddr[0]), .dout(slot0_dout), .ok(slot0_ok));

  jtpang_sched_cache #(.AW(SLOT1_AW), .DW(SLOT1_DW), .OFFSET(SLOT1_OFFSET)) u_slot1 (
    .clk(clk), .rst(rst), .addr(slot1_addr), .cs(slot1_cs), .busy(busy[1]),
    .grant(grant[1]), .fill(fill[1]), .fill_data(fill_word[CW1-1:0]),
    .pending(pend[1]), .word_addr(waddr[1]), .dout(slot1_dout), .ok(slot1_ok));

  jtpang_sched_cache #(.AW(SLOT2_AW), .DW(SLOT2_DW), .OFFSET(SLOT2_OFFSET)) u_slot2 (
    .clk(clk), .rst(rst), .addr(slot2_addr), .cs(slot2_cs), .busy(busy[2]),
    .grant(grant[2]), .fill(fill[2]), .fill_data(fill_word[CW2-1:0]),
    .pending(pend[2]), .word_addr(waddr[2]), .dout(slot2_dout), .ok(slot2_ok));
endmodule

// File: tb/tb_jtpang_bank_sched.sv
// Bench for jtpang_bank_sched: slot0 byte-wide, slot1 16-bit at a wrapping
// offset, slot2 32-bit, against a word-level bank model.
module tb_jtpang_bank_sched;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [17:0] a0, a1, a2;
  logic        cs0, cs1, cs2, ok0, ok1, ok2;
  logic [7:0]  d0;
  logic [15:0] d1;
  logic [31:0] d2;

  jtpang_bank_sched_if bif();

  jtpang_bank_sched #(
    .SLOT0_AW(18), .SLOT0_DW(8),  .SLOT0_OFFSET(22'h0),
    .SLOT1_AW(18), .SLOT1_DW(16), .SLOT1_OFFSET(22'h3FFFFF),
    .SLOT2_AW(18), .SLOT2_DW(32), .SLOT2_OFFSET(22'h10000)
  ) dut (
    .clk(clk), .rst(rst),
    .slot0_addr(a0), .slot0_cs(cs0), .slot0_dout(d0), .slot0_ok(ok0),
    .slot1_addr(a1), .slot1_cs(cs1), .slot1_dout(d1), .slot1_ok(ok1),
    .slot2_addr(a2), .slot2_cs(cs2), .slot2_dout(d2), .slot2_ok(ok2),
    .bank(bif));

  int vecs = 0, errs = 0;
  int rr = 0;
  logic auto_resp = 1'b1, acked = 1'b0;
  logic [21:0] req_log[$];

  function automatic logic [15:0] mem(logic [21:0] a);
    logic [21:0] h;
    case (a)
      22'h1:     return 16'hBEEF;
      22'h1000A: return 16'h1234;
      22'h1000B: return 16'h5678;
      default: begin
        h = a * 22'h193 + 22'h3C5A1;
        return h[15:0] ^ {a[7:0], a[15:8]};
      end
    endcase
  endfunction

  function automatic logic [21:0] exp_word(int s, logic [17:0] ad);
    longint w;
    case (s)
      0:       w = longint'(ad) / 2;
      1:       w = 64'h3FFFFF + longint'(ad);
      default: w = 64'h10000 + 2 * longint'(ad);
    endcase
    return 22'(w % (longint'(1) << 22));
  endfunction

  function automatic logic [31:0] exp_data(int s, logic [17:0] ad);
    logic [21:0] w;
    logic [15:0] lo16;
    w = exp_word(s, ad);
    lo16 = mem(w);
    case (s)
      0:       return ad[0] ? {24'h0, lo16[15:8]} : {24'h0, lo16[7:0]};
      1:       return {16'h0, lo16};
      default: return {mem(w + 22'h1), lo16};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ok(input logic [2:0] m, input string tag);
    int n = 0;
    while (n < 300 && (({ok2, ok1, ok0} & m) != m)) begin step(); n++; end
    check(tag, {29'h0, {ok2, ok1, ok0} & m}, {29'h0, m});
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (n < 100 && !bif.sdram_req) begin step(); n++; end
    check(tag, {31'h0, bif.sdram_req}, 32'h1);
  endtask

  // All three slots miss together; grant order comes from the arbitration rule.
  task automatic run_round(input logic [17:0] x0, x1, x2, input string tag);
    logic [17:0] ad [3];
    logic [2:0]  pend;
    int          exp_s [3];
    int          base, start, s;
    ad[0] = x0; ad[1] = x1; ad[2] = x2;
    base = req_log.size();
    a0 = x0; a1 = x1; a2 = x2; cs0 = 1; cs1 = 1; cs2 = 1;
    step();
    wait_ok(3'b111, {tag, "_ok"});
    pend = 3'b111;
    for (int k = 0; k < 3; k++) begin
`ifdef JTPANG_SCHED_FIXPRIO_EN
      start = 0;
`else
      start = rr;
`endif
      s = -1;
      for (int j = 0; j < 3; j++)
        if (s < 0 && pend[(start + j) % 3]) s = (start + j) % 3;
      exp_s[k] = s; pend[s] = 1'b0; rr = (s + 1) % 3;
    end
    check({tag, "_nreq"}, req_log.size() - base, 3);
    for (int k = 0; k < 3; k++)
      if (req_log.size() > base + k)
        check($sformatf("%s_order%0d", tag, k), {10'h0, req_log[base + k]},
              {10'h0, exp_word(exp_s[k], ad[exp_s[k]])});
    check({tag, "_d0"}, {24'h0, d0}, exp_data(0, x0));
    check({tag, "_d1"}, {16'h0, d1}, exp_data(1, x1));
    check({tag, "_d2"}, d2, exp_data(2, x2));
  endtask

  // Bank responder: 16-bit words return dst+rdy together, 32-bit ones in two beats.
  initial begin
    logic [21:0] a;
    logic        is32;
    bif.sdram_ack = 0; bif.data_dst = 0; bif.data_rdy = 0; bif.data_read = '0;
    forever begin
      @(negedge clk);
      if (auto_resp && bif.sdram_req && !rst) begin
        a = bif.sdram_addr;
        req_log.push_back(a);
        is32 = (a[21:16] == 6'h01);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bif.sdram_ack = 1; @(negedge clk); bif.sdram_ack = 0; acked = 1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        bif.data_dst = 1; bif.data_rdy = !is32; bif.data_read = mem(a);
        @(negedge clk); bif.data_dst = 0; bif.data_rdy = 0;
        if (is32) begin
          bif.data_rdy = 1; bif.data_read = mem(a + 22'h1);
          @(negedge clk); bif.data_rdy = 0;
        end
      end
    end
  end

  // Whenever ok is up, dout must match the address presented one edge earlier.
  initial begin
    logic [17:0] p0, p1, p2;
    logic        c0, c1, c2, rp;
    forever begin
      @(posedge clk); p0 = a0; p1 = a1; p2 = a2; c0 = cs0; c1 = cs1; c2 = cs2; rp = rst;
      @(negedge clk);
      if (rp) check("mon_rst_ok", {29'h0, ok2, ok1, ok0}, 32'h0);
      if (ok0) begin check("mon_cs0", {31'h0, c0}, 32'h1); check("mon_d0", {24'h0, d0}, exp_data(0, p0)); end
      if (ok1) begin check("mon_cs1", {31'h0, c1}, 32'h1); check("mon_d1", {16'h0, d1}, exp_data(1, p1)); end
      if (ok2) begin check("mon_cs2", {31'h0, c2}, 32'h1); check("mon_d2", d2, exp_data(2, p2)); end
    end
  end

  initial begin
    int base, n;
    a0 = '0; a1 = '0; a2 = '0; cs0 = 0; cs1 = 0; cs2 = 0;
    repeat (3) step();
    check("rst_req",  {31'h0, bif.sdram_req}, 32'h0);
    check("rst_addr", {10'h0, bif.sdram_addr}, 32'h0);
    check("rst_ok",   {29'h0, ok2, ok1, ok0}, 32'h0);
    check("rst_dout0", {24'h0, d0}, 32'h0);
    check("rst_dout1", {16'h0, d1}, 32'h0);
    check("rst_dout2", d2, 32'h0);
    rst = 0;

    run_round(18'h10, 18'h21, 18'h3, "rr1");
    cs1 = 0; cs2 = 0; a0 = 18'h12; step();
    wait_ok(3'b001, "lone_ok");
    rr = 1;
    run_round(18'h14, 18'h22, 18'h4, "rr2");

    // Byte slot: high lane first, then the other lane of the same word as a hit.
    cs0 = 0; cs1 = 0; cs2 = 0; step();
    base = req_log.size();
    a0 = 18'h3; cs0 = 1; step();
    check("beef_req",  {31'h0, bif.sdram_req}, 32'h1);
    check("beef_addr", {10'h0, bif.sdram_addr}, 32'h1);
    wait_ok(3'b001, "beef_ok");
    check("beef_dout", {24'h0, d0}, 32'hBE);
    check("beef_nreq", req_log.size() - base, 1);
    a0 = 18'h2; step();
    check("lane_ok",    {31'h0, ok0}, 32'h1);
    check("lane_dout",  {24'h0, d0}, 32'hEF);
    check("lane_noreq", {31'h0, bif.sdram_req}, 32'h0);
    repeat (3) step();
    check("lane_nreq", req_log.size() - base, 1);

    // 32-bit slot assembles {rdy word, dst word}.
    cs0 = 0; base = req_log.size();
    a2 = 18'h5; cs2 = 1; step();
    wait_ok(3'b100, "w32_ok");
    check("w32_addr", (req_log.size() > base) ? {10'h0, req_log[base]} : 32'hFFFFFFFF, 32'h1000A);
    check("w32_dout", d2, 32'h56781234);

    // Offset sum wraps to 22 bits.
    cs2 = 0; base = req_log.size();
    a1 = 18'h2; cs1 = 1; step();
    wait_ok(3'b010, "wrap_ok");
    check("wrap_addr", (req_log.size() > base) ? {10'h0, req_log[base]} : 32'hFFFFFFFF, 32'h1);
    check("wrap_dout", {16'h0, d1}, 32'hBEEF);

    // Address moves while the first fill is in flight.
    cs1 = 0; step();
    base = req_log.size(); acked = 0;
    a1 = 18'h100; cs1 = 1; step();
    n = 0;
    while (n < 100 && !acked) begin step(); n++; end
    check("chg_acked", {31'h0, acked}, 32'h1);
    a1 = 18'h200;
    n = 0;
    while (n < 200 && req_log.size() < base + 2) begin step(); n++; end
    check("chg_ok_low", {31'h0, ok1}, 32'h0);
    check("chg_nreq", req_log.size() - base, 2);
    if (req_log.size() >= base + 2) begin
      check("chg_first",  {10'h0, req_log[base]},     {10'h0, exp_word(1, 18'h100)});
      check("chg_second", {10'h0, req_log[base + 1]}, {10'h0, exp_word(1, 18'h200)});
    end
    wait_ok(3'b010, "chg_ok");
    check("chg_dout", {16'h0, d1}, exp_data(1, 18'h200));

    // Reset while the second beat of a 32-bit fill is awaited.
    cs1 = 0; step();
    auto_resp = 0;
    a2 = 18'h7; cs2 = 1; step();
    wait_req("rs_req");
    bif.sdram_ack = 1; step();
    bif.sdram_ack = 0; bif.data_dst = 1; bif.data_read = mem(exp_word(2, 18'h7)); step();
    bif.data_dst = 0; rst = 1; cs2 = 0; step();
    check("rs_req_low", {31'h0, bif.sdram_req}, 32'h0);
    check("rs_ok_low",  {29'h0, ok2, ok1, ok0}, 32'h0);
    rst = 0;
    bif.data_rdy = 1; bif.data_read = mem(exp_word(2, 18'h7) + 22'h1); step();
    bif.data_rdy = 0; bif.data_dst = 1; step();
    bif.data_dst = 0; step();
    check("rs_stale_noreq", {31'h0, bif.sdram_req}, 32'h0);
    cs2 = 1; step();
    check("rs_rereq",      {31'h0, bif.sdram_req}, 32'h1);
    check("rs_rereq_addr", {10'h0, bif.sdram_addr}, {10'h0, exp_word(2, 18'h7)});
    check("rs_ok2_low",    {31'h0, ok2}, 32'h0);
    auto_resp = 1;
    wait_ok(3'b100, "rs_ok");
    check("rs_dout", d2, exp_data(2, 18'h7));

    // Random traffic; the monitor checks every ok cycle against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 7) == 0) a0 = 18'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a1 = 18'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a2 = 18'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) cs0 = !cs0;
      if ($urandom_range(0, 9) == 0) cs1 = !cs1;
      if ($urandom_range(0, 9) == 0) cs2 = !cs2;
      step();
    end
    cs0 = 1; cs1 = 1; cs2 = 1; step();
    wait_ok(3'b111, "rand_final_ok");
    check("rand_d0", {24'h0, d0}, exp_data(0, a0));
    check("rand_d1", {16'h0, d1}, exp_data(1, a1));
    check("rand_d2", d2, exp_data(2, a2));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
